sqrt_job_arbiter: RTL and testbench

//  Shares one iterative integer square-root datapath (start/pronto control unit

---
 rtl/sqrt_job_arbiter.sv | 144 ++++++++++++++
 tb/tb_sqrt_job_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_job_arbiter.sv
// sqrt_job_arbiter: shares one iterative square-root control unit/datapath
// among NREQ requesters. Requesters are picked round-robin and served one
// job at a time. The operand is latched into dp_x, and dp_start is held
// until pronto. The root is returned with a one-cycle ack. A job that never
// completes is aborted after TIMEOUT run cycles and reported with err.
module sqrt_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] req_x_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [W/2-1:0]    res_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              dp_start_o,
  output logic [W-1:0]      dp_x_o,
  input  logic              dp_pronto_i,
  input  logic [W/2-1:0]    dp_res_i
);

  localparam int RW = W / 2;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gid_q;
  logic [TW-1:0]   timer_q;
  logic [W-1:0]    dp_x_q;
  logic [NREQ-1:0] ack_q;
  logic [RW-1:0]   res_q;
  logic            err_q;
  logic            busy_q;
  logic            dp_start_q;

  // Candidate requester for each search position, starting just after ptr.
  logic [PW-1:0]   cand_idx [NREQ];
  // One-hot decode of the granted requester, used to build the ack pulse.
  logic [NREQ-1:0] gid_onehot;

  logic            win_valid_d;
  logic [PW-1:0]   win_idx_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum = {1'b0, ptr_q} + (PW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                   : sum[PW-1:0];
      assign gid_onehot[gi] = (gid_q == PW'(gi));
    end
  endgenerate

  // Round-robin search: the first requesting candidate after ptr wins.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_valid_d && req_i[cand_idx[k]]) begin
        win_valid_d = 1'b1;
        win_idx_d   = cand_idx[k];
      end
    end
  end

  // Job FSM with every output registered. ack/res/err default to zero, so
  // they pulse for exactly the DONE/ABORT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      gid_q      <= '0;
      timer_q    <= '0;
      dp_x_q     <= '0;
      ack_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      dp_start_q <= 1'b0;
    end else begin
      ack_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid_d) begin
            gid_q      <= win_idx_d;
            ptr_q      <= win_idx_d;
            dp_x_q     <= req_x_i[win_idx_d*W +: W];
            timer_q    <= '0;
            dp_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          timer_q <= timer_q + TW'(1);
          // Pronto takes priority over the watchdog in the final cycle.
          if (dp_pronto_i) begin
            res_q      <= dp_res_i;
            ack_q      <= gid_onehot;
            dp_start_q <= 1'b0;
            state_q    <= S_DONE;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            ack_q      <= gid_onehot;
            err_q      <= 1'b1;
            dp_start_q <= 1'b0;
            state_q    <= S_ABORT;
          end
        end
        S_DONE, S_ABORT: begin
          // dp_start is low for this cycle, so the control unit returns to idle.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q     <= 1'b0;
          dp_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign res_o      = res_q;
  assign err_o      = err_q;
  assign busy_o     = busy_q;
  assign dp_start_o = dp_start_q;
  assign dp_x_o     = dp_x_q;

endmodule

// File: tb/tb_sqrt_job_arbiter.sv
// Directed testbench for sqrt_job_arbiter. A small behavioural model of the
// sqrt datapath raises pronto after a programmable number of start cycles
// (0 = never) and returns the floor square root of dp_x.
module tb_sqrt_job_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [3:0]  ack;
  logic [3:0]  res;
  logic        err;
  logic        busy;
  logic        dp_start;
  logic [7:0]  dp_x;
  logic        dp_pronto;
  logic [3:0]  dp_res;

  int pronto_after;
  int run_cnt;
  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_root [4];

  always #5 clk = ~clk;

  sqrt_job_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .req_x_i    (req_x),
    .ack_o      (ack),
    .res_o      (res),
    .err_o      (err),
    .busy_o     (busy),
    .dp_start_o (dp_start),
    .dp_x_o     (dp_x),
    .dp_pronto_i(dp_pronto),
    .dp_res_i   (dp_res)
  );

  function automatic logic [3:0] isqrt8(input logic [7:0] x);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++)
      if (i * i <= int'(x)) r = 4'(i);
    return r;
  endfunction

  // Datapath model: counts consecutive start cycles.
  always @(posedge clk) begin
    if (rst || !dp_start) run_cnt <= 0;
    else run_cnt <= run_cnt + 1;
  end
  assign dp_pronto = dp_start && (pronto_after != 0) && (run_cnt == pronto_after - 1);
  assign dp_res    = isqrt8(dp_x);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for one ack and reports what was seen. It does no checking.
  task automatic run_job(input int budget, input bit drop, output bit seen,
                         output int starts, output logic [7:0] dpx_seen,
                         output logic [3:0] ack_seen, output logic [3:0] res_seen,
                         output logic err_seen);
    seen = 1'b0; starts = 0; dpx_seen = 8'h0;
    ack_seen = 4'b0; res_seen = 4'b0; err_seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dp_start) begin
        if (starts == 0) dpx_seen = dp_x;
        starts++;
      end
      if (ack !== 4'b0) begin
        seen = 1'b1; ack_seen = ack; res_seen = res; err_seen = err;
        if (drop) req = req & ~ack;
        break;
      end
    end
    $display("job: ack=%b res=%0d err=%b starts=%0d dp_x=%0d seen=%0b",
             ack_seen, res_seen, err_seen, starts, dpx_seen, seen);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0; req_x = 32'h0; pronto_after = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack, res, err, busy, dp_start, dp_x} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b res=%0d err=%b busy=%b start=%b dp_x=%0d required all 0",
               ack, res, err, busy, dp_start, dp_x);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || dp_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b start=%b required 0 0", busy, dp_start);
    end
  endtask

  task automatic test_single_job();
    bit s; int st; logic [7:0] dx; logic [3:0] a, r; logic e;
    do_reset();
    req_x[2*8 +: 8] = 8'd49;
    pronto_after = 5;
    req = 4'b0100;
    run_job(40, 1'b1, s, st, dx, a, r, e);
    n_cmp++;
    if (!s) begin n_err++; $display("FAIL t1_ack_timeout: got no ack required ack"); end
    n_cmp++;
    if (dx !== 8'd49) begin n_err++; $display("FAIL t1_dp_x: got %0d required 49", dx); end
    n_cmp++;
    if (st !== 5) begin n_err++; $display("FAIL t1_start_cycles: got %0d required 5", st); end
    n_cmp++;
    if (a !== 4'b0100 || r !== 4'd7 || e !== 1'b0) begin
      n_err++;
      $display("FAIL t1_result: got ack=%b res=%0d err=%b required 0100 7 0", a, r, e);
    end
    @(negedge clk);
    n_cmp++;
    if (ack !== 4'b0 || res !== 4'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_after_ack: got ack=%b res=%0d busy=%b required 0000 0 0", ack, res, busy);
    end
  endtask

  task automatic test_priority_after_reset();
    bit s; int st; logic [7:0] dx; logic [3:0] a, r; logic e;
    do_reset();
    req_x[1*8 +: 8] = 8'd16;
    req_x[3*8 +: 8] = 8'd100;
    pronto_after = 3;
    req = 4'b1010;
    run_job(40, 1'b1, s, st, dx, a, r, e);
    n_cmp++;
    if (!s || a !== 4'b0010 || r !== 4'd4) begin
      n_err++;
      $display("FAIL t2_first: got seen=%0b ack=%b res=%0d required 1 0010 4", s, a, r);
    end
    run_job(40, 1'b1, s, st, dx, a, r, e);
    n_cmp++;
    if (!s || a !== 4'b1000 || r !== 4'd10) begin
      n_err++;
      $display("FAIL t2_second: got seen=%0b ack=%b res=%0d required 1 1000 10", s, a, r);
    end
  endtask

  task automatic test_round_robin();
    bit s; int st; logic [7:0] dx; logic [3:0] a, r; logic e;
    logic [3:0] exp_ack;
    do_reset();
    req_x = {8'd255, 8'd200, 8'd1, 8'd0};
    exp_root[0] = 4'd0; exp_root[1] = 4'd1; exp_root[2] = 4'd14; exp_root[3] = 4'd15;
    pronto_after = 2;
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      run_job(40, 1'b0, s, st, dx, a, r, e);
      exp_ack = 4'b0001 << (j % 4);
      n_cmp++;
      if (!s || a !== exp_ack || r !== exp_root[j % 4] || e !== 1'b0) begin
        n_err++;
        $display("FAIL t3_job%0d: got seen=%0b ack=%b res=%0d err=%b required ack=%b res=%0d err=0",
                 j, s, a, r, e, exp_ack, exp_root[j % 4]);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_timeout();
    bit s; int st; logic [7:0] dx; logic [3:0] a, r; logic e;
    do_reset();
    req_x[1*8 +: 8] = 8'd9;
    pronto_after = 0;
    req = 4'b0010;
    run_job(200, 1'b1, s, st, dx, a, r, e);
    n_cmp++;
    if (!s || st !== 64) begin
      n_err++;
      $display("FAIL t4_timeout_cycles: got seen=%0b starts=%0d required 1 64", s, st);
    end
    n_cmp++;
    if (a !== 4'b0010 || r !== 4'd0 || e !== 1'b1) begin
      n_err++;
      $display("FAIL t4_abort: got ack=%b res=%0d err=%b required 0010 0 1", a, r, e);
    end
    @(negedge clk);
    req_x[1*8 +: 8] = 8'd144;
    pronto_after = 2;
    req = 4'b0010;
    run_job(40, 1'b1, s, st, dx, a, r, e);
    n_cmp++;
    if (!s || a !== 4'b0010 || r !== 4'd12 || e !== 1'b0) begin
      n_err++;
      $display("FAIL t4_recover: got seen=%0b ack=%b res=%0d err=%b required 1 0010 12 0", s, a, r, e);
    end
  endtask

  task automatic test_reset_mid_run();
    bit s; int st; logic [7:0] dx; logic [3:0] a, r; logic e;
    int acks;
    do_reset();
    req_x[0 +: 8] = 8'd100;
    pronto_after = 0;
    req = 4'b0001;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (dp_start !== 1'b1) begin n_err++; $display("FAIL t5_running: got start=%b required 1", dp_start); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ack, res, err, busy, dp_start, dp_x} !== 19'h0) begin
      n_err++;
      $display("FAIL t5_reset_outputs: got ack=%b res=%0d err=%b busy=%b start=%b dp_x=%0d required all 0",
               ack, res, err, busy, dp_start, dp_x);
    end
    rst = 1'b0;
    req = 4'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack !== 4'b0) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin n_err++; $display("FAIL t5_no_ack: got %0d acks required 0", acks); end
    req_x[3*8 +: 8] = 8'd255;
    pronto_after = 4;
    req = 4'b1000;
    run_job(40, 1'b1, s, st, dx, a, r, e);
    n_cmp++;
    if (!s || a !== 4'b1000 || r !== 4'd15 || e !== 1'b0) begin
      n_err++;
      $display("FAIL t5_after: got seen=%0b ack=%b res=%0d err=%b required 1 1000 15 0", s, a, r, e);
    end
  endtask

  task automatic test_back_to_back();
    bit s; int st; logic [7:0] dx; logic [3:0] a, r; logic e;
    int gap;
    do_reset();
    req_x[2*8 +: 8] = 8'd225;
    pronto_after = 64;
    req = 4'b0100;
    run_job(200, 1'b0, s, st, dx, a, r, e);
    n_cmp++;
    if (!s || st !== 64) begin
      n_err++;
      $display("FAIL t6_last_cycle_starts: got seen=%0b starts=%0d required 1 64", s, st);
    end
    n_cmp++;
    if (a !== 4'b0100 || r !== 4'd15 || e !== 1'b0) begin
      n_err++;
      $display("FAIL t6_pronto_wins: got ack=%b res=%0d err=%b required 0100 15 0", a, r, e);
    end
    pronto_after = 1;
    gap = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      gap++;
      if (dp_start) break;
    end
    n_cmp++;
    if (gap !== 2 || dp_start !== 1'b1) begin
      n_err++;
      $display("FAIL t6_gap: got gap=%0d start=%b required 2 1", gap, dp_start);
    end
    @(negedge clk);
    $display("job: ack=%b res=%0d err=%b (back-to-back)", ack, res, err);
    n_cmp++;
    if (ack !== 4'b0100 || res !== 4'd15 || err !== 1'b0) begin
      n_err++;
      $display("FAIL t6_second_job: got ack=%b res=%0d err=%b required 0100 15 0", ack, res, err);
    end
    req = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; req_x = 32'h0; pronto_after = 0;
    test_reset();
    test_single_job();
    test_priority_after_reset();
    test_round_robin();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
